// File: rtl/sad_min_tracker.sv
// sad_min_tracker: drives ctr via turnenable, tracks min SAD and its raster position, returns best mv on a valid/ready port
module sad_min_tracker #(
  parameter int SAD_W = 16,
  parameter int NPE   = 16,
  parameter int NROWS = 16,
  parameter int SR    = 8,
  parameter int MV_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             turnenable,
  input  logic [3:0]       select4bit,
  input  logic             sad_valid,
  input  logic [SAD_W-1:0] sad_in,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SAD_W-1:0] min_sad,
  output logic [MV_W-1:0]  mv_x,
  output logic [MV_W-1:0]  mv_y,
  output logic             seq_err
);
  localparam int CW = $clog2(NPE);
  localparam int RW = $clog2(NROWS);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CW-1:0] col, best_col, nb_col;
  logic [RW-1:0] row, best_row, nb_row;
  logic lt, col_end, last;
  assign lt      = sad_in < min_sad;
  assign nb_col  = lt ? col : best_col;
  assign nb_row  = lt ? row : best_row;
  assign col_end = col == CW'(NPE - 1);
  assign last    = col_end && row == RW'(NROWS - 1);
  assign busy    = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      turnenable <= 1'b0;
      res_valid  <= 1'b0;
      min_sad    <= '1;
      mv_x       <= '0;
      mv_y       <= '0;
      seq_err    <= 1'b0;
      col        <= '0;
      row        <= '0;
      best_col   <= '0;
      best_row   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state      <= RUN;
          turnenable <= 1'b1;
          col        <= '0;
          row        <= '0;
          seq_err    <= 1'b0;
          min_sad    <= '1;
          best_col   <= '0;
          best_row   <= '0;
        end
        RUN: if (sad_valid) begin
          if (select4bit != 4'(col)) seq_err <= 1'b1;
          // strict compare keeps the earliest raster-order candidate on ties
          if (lt) begin
            min_sad  <= sad_in;
            best_col <= col;
            best_row <= row;
          end
          col <= col_end ? '0 : col + CW'(1);
          if (col_end) row <= row + RW'(1);
          if (last) begin
            state      <= DONE;
            turnenable <= 1'b0;
            res_valid  <= 1'b1;
            mv_x       <= MV_W'({1'b0, nb_col}) - MV_W'(SR);
            mv_y       <= MV_W'({1'b0, nb_row}) - MV_W'(SR);
          end
        end
        DONE: if (res_ready) begin
          state     <= IDLE;
          res_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
